// File: rtl/restoring_divider.sv
// Signed W-bit restoring divider: one quotient bit per clock on operand magnitudes,
// with the signs fixed up afterwards. Divide-by-zero and overflow are flagged with the result.
module restoring_divider #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] X,
  input  logic signed [W-1:0] Y,
  output logic signed [W-1:0] Q,
  output logic signed [W-1:0] R,
  output logic                valid,
  output logic                busy,
  output logic                dz,
  output logic                ovf
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic           sx_r;
  logic           sy_r;
  logic           dz_path_r;
  logic           ovf_cand_r;
  logic [W-1:0]   m_r;
  logic [W-1:0]   q_r;
  logic [W-1:0]   ymag_r;
  logic [W-1:0]   x_r;
  logic [W:0]     a_r;
  logic [CW-1:0]  cnt_r;
  logic [W:0]     a_sh_s;
  logic [W:0]     diff_s;
  logic           last_s;

  function automatic logic [W-1:0] neg2(input logic [W-1:0] v);
    return ~v + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // The most negative value maps to its unsigned magnitude 2^(W-1).
  function automatic logic [W-1:0] mag(input logic [W-1:0] v);
    return v[W-1] ? neg2(v) : v;
  endfunction

  // One restoring step: shift dividend bit into A, trial-subtract the divisor.
  always_comb begin
    a_sh_s = {a_r[W-1:0], m_r[W-1]};
    diff_s = a_sh_s - {1'b0, ymag_r};
    last_s = (cnt_r == CW'(W - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (Y == {W{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = SIGN;
        end else begin
          state_s = CALC;
        end
      end
      SIGN:    state_s = DONE;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sx_r       <= 1'b0;
      sy_r       <= 1'b0;
      dz_path_r  <= 1'b0;
      ovf_cand_r <= 1'b0;
      m_r        <= {W{1'b0}};
      q_r        <= {W{1'b0}};
      ymag_r     <= {W{1'b0}};
      x_r        <= {W{1'b0}};
      a_r        <= {(W+1){1'b0}};
      cnt_r      <= {CW{1'b0}};
      Q          <= {W{1'b0}};
      R          <= {W{1'b0}};
      valid      <= 1'b0;
      busy       <= 1'b0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      valid <= 1'b0;
      busy  <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (start) begin
            sx_r       <= X[W-1];
            sy_r       <= Y[W-1];
            m_r        <= mag(X);
            ymag_r     <= mag(Y);
            x_r        <= X;
            q_r        <= {W{1'b0}};
            a_r        <= {(W+1){1'b0}};
            cnt_r      <= {CW{1'b0}};
            dz_path_r  <= (Y == {W{1'b0}});
            ovf_cand_r <= (X == {1'b1, {(W-1){1'b0}}}) && (Y == {W{1'b1}});
          end
        end
        CALC: begin
          a_r   <= diff_s[W] ? a_sh_s : diff_s;
          m_r   <= {m_r[W-2:0], 1'b0};
          q_r   <= {q_r[W-2:0], ~diff_s[W]};
          cnt_r <= cnt_r + CW'(1);
        end
        SIGN: begin
          Q     <= (sx_r ^ sy_r) ? neg2(q_r) : q_r;
          R     <= sx_r ? neg2(a_r[W-1:0]) : a_r[W-1:0];
          dz    <= 1'b0;
          ovf   <= ovf_cand_r;
          valid <= 1'b1;
        end
        DONE: begin
          // Divide-by-zero skips CALC/SIGN and publishes here instead.
          if (dz_path_r) begin
            Q         <= {W{1'b0}};
            R         <= x_r;
            dz        <= 1'b1;
            ovf       <= 1'b0;
            valid     <= 1'b1;
            dz_path_r <= 1'b0;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
